// File: rtl/jk_excite_ctrl.sv
// Target-driven controller for a bank of JK flip-flops: computes J/K from live Q,
// drives them for one clock, then checks the bank against the requested state.

module jk_excite_bit #(
    parameter logic DC_FILL = 1'b0
) (
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);
    // Whichever input the transition leaves as don't-care takes DC_FILL.
    assign j = q ? DC_FILL : t;
    assign k = q ? ~t      : DC_FILL;
endmodule

module jk_excite_ctrl #(
    parameter int   WIDTH   = 4,
    parameter logic DC_FILL = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tgt_valid,
    output logic                       tgt_ready,
    input  logic [WIDTH-1:0]           tgt_data,
    input  logic [WIDTH-1:0]           q_fb,
    output logic [WIDTH-1:0]           j,
    output logic [WIDTH-1:0]           k,
    output logic                       busy,
    output logic                       done,
    output logic                       mismatch,
    output logic [WIDTH-1:0]           err_mask,
    output logic [$clog2(WIDTH+1)-1:0] chg_cnt,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t state;

    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    chg_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_excite_bit #(.DC_FILL(DC_FILL)) u_bit (
                .q (q_fb[gi]),
                .t (tgt_data[gi]),
                .j (j_nxt[gi]),
                .k (k_nxt[gi])
            );
        end
    endgenerate

    assign diff = q_fb ^ tgt_data;

    always_comb begin
        chg_nxt = '0;
        for (int i = 0; i < WIDTH; i++)
            chg_nxt = chg_nxt + CW'(diff[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            tgt_q     <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            err_mask  <= '0;
            chg_cnt   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt_data;
                        j         <= j_nxt;
                        k         <= k_nxt;
                        chg_cnt   <= chg_nxt;
                        tgt_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    err_mask <= q_fb ^ tgt_q;
                    if (q_fb == tgt_q) begin
                        done <= 1'b1;
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        mismatch <= 1'b1;
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    end
                    tgt_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    j         <= '0;
                    k         <= '0;
                    tgt_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Directed bench: two controllers (hold- and toggle-preferring, wide and narrow
// counters) each driving a behavioural JK bank; bank 0 can have stuck-at-0 bits.

module tb_jk_excite_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic [3:0] bank0, bank1, ld_val, stuck0;
    logic       ld_en;

    logic       rdy0, busy0, done0, mis0, rdy1, busy1, done1, mis1;
    logic [3:0] j0, k0, em0, j1, k1, em1;
    logic [2:0] chg0, chg1;
    logic [7:0] pass0, fail0;
    logic [1:0] pass1, fail1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_excite_ctrl #(.WIDTH(4), .DC_FILL(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
        .tgt_data(tgt_data), .q_fb(bank0), .j(j0), .k(k0), .busy(busy0),
        .done(done0), .mismatch(mis0), .err_mask(em0), .chg_cnt(chg0),
        .pass_cnt(pass0), .fail_cnt(fail0));

    jk_excite_ctrl #(.WIDTH(4), .DC_FILL(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
        .tgt_data(tgt_data), .q_fb(bank1), .j(j1), .k(k1), .busy(busy1),
        .done(done1), .mismatch(mis1), .err_mask(em1), .chg_cnt(chg1),
        .pass_cnt(pass1), .fail_cnt(fail1));

    always @(posedge clk) begin
        if (ld_en) begin
            bank0 <= ld_val;
            bank1 <= ld_val;
        end else begin
            bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & ~stuck0;
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        ld_en  = 1'b1;
        ld_val = v;
        step();
        ld_en  = 1'b0;
    endtask

    // Loads the banks, then offers one target; returns just after E0.
    task automatic accept(input logic [3:0] q0, input logic [3:0] t);
        load(q0);
        tgt_valid = 1'b1;
        tgt_data  = t;
        step();
        tgt_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tgt_valid = 1'b0; tgt_data = '0;
        ld_en = 1'b1; ld_val = '0; stuck0 = '0;
        step(); step();
        chk("rst_j",    j0,    4'h0);
        chk("rst_k",    k0,    4'h0);
        chk("rst_done", done0, 1'b0);
        chk("rst_mis",  mis0,  1'b0);
        chk("rst_em",   em0,   4'h0);
        chk("rst_chg",  chg0,  3'd0);
        chk("rst_pass", pass0, 8'd0);
        chk("rst_fail", fail0, 8'd0);
        chk("rst_busy", busy0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_rdy",  rdy0,  1'b1);

        // 0000 -> 1010
        accept(4'b0000, 4'b1010);
        chk("t1_j0",   j0,    4'b1010);
        chk("t1_k0",   k0,    4'b0000);
        chk("t1_j1",   j1,    4'b1010);
        chk("t1_k1",   k1,    4'b1111);
        chk("t1_chg",  chg0,  3'd2);
        chk("t1_rdy",  rdy0,  1'b0);
        chk("t1_busy", busy0, 1'b1);
        step();
        chk("t1_q0",   bank0, 4'b1010);
        chk("t1_jz",   j0,    4'b0000);
        chk("t1_nd",   done0, 1'b0);
        step();
        chk("t1_done", done0, 1'b1);
        chk("t1_mis",  mis0,  1'b0);
        chk("t1_em",   em0,   4'b0000);
        chk("t1_pass", pass0, 8'd1);
        chk("t1_rdy2", rdy0,  1'b1);
        step();
        chk("t1_dpls", done0, 1'b0);

        // 1010 -> 0101
        accept(4'b1010, 4'b0101);
        chk("t2_j0",  j0,   4'b0101);
        chk("t2_k0",  k0,   4'b1010);
        chk("t2_j1",  j1,   4'b1111);
        chk("t2_k1",  k1,   4'b1111);
        chk("t2_chg", chg0, 3'd4);
        step();
        chk("t2_q0",  bank0, 4'b0101);
        chk("t2_q1",  bank1, 4'b0101);
        step();
        chk("t2_d0",  done0, 1'b1);
        chk("t2_d1",  done1, 1'b1);

        // Hold 0110
        accept(4'b0110, 4'b0110);
        chk("t3_j0",  j0,   4'b0000);
        chk("t3_k0",  k0,   4'b0000);
        chk("t3_chg", chg0, 3'd0);
        chk("t3_j1",  j1,   4'b0110);
        chk("t3_k1",  k1,   4'b1001);
        step();
        chk("t3_q0",  bank0, 4'b0110);
        step();
        chk("t3_d0",  done0, 1'b1);
        chk("t3_p0",  pass0, 8'd3);
        chk("t3_p1",  pass1, 2'd3);

        // Bank 0 bit0 stuck at 0
        stuck0 = 4'b0001;
        accept(4'b0000, 4'b0001);
        chk("t4_j0",  j0, 4'b0001);
        step();
        chk("t4_q0",  bank0, 4'b0000);
        step();
        chk("t4_mis", mis0,  1'b1);
        chk("t4_dn",  done0, 1'b0);
        chk("t4_em",  em0,   4'b0001);
        chk("t4_f0",  fail0, 8'd1);
        chk("t4_p0",  pass0, 8'd3);
        chk("t4_d1",  done1, 1'b1);
        stuck0 = 4'b0000;
        step();
        chk("t4_mpl", mis0, 1'b0);

        // Fifth pass for the 2-bit counter
        accept(4'b0000, 4'b0000);
        step(); step();
        chk("t5_p0",  pass0, 8'd4);
        chk("t5_em",  em0,   4'b0000);
        chk("t5_sat", pass1, 2'd3);

        // Async reset during DRIVE
        accept(4'b0000, 4'b1111);
        chk("t6_j0",  j0, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_jz",  j0,    4'b0000);
        chk("t6_kz",  k1,    4'b0000);
        chk("t6_by",  busy0, 1'b0);
        chk("t6_p0",  pass0, 8'd0);
        chk("t6_f0",  fail0, 8'd0);
        step();
        reset = 1'b0;
        #1;
        chk("t6_rdy", rdy0, 1'b1);
        step();
        chk("t6_nd",  done0, 1'b0);
        chk("t6_nm",  mis0,  1'b0);
        chk("t6_q0",  bank0, 4'b0000);
        chk("t6_p1",  pass1, 2'd0);

        // tgt_valid held high: back-to-back accepts 3 cycles apart
        load(4'b0000);
        tgt_valid = 1'b1;
        tgt_data  = 4'b0011;
        step();
        chk("t7_j0a", j0,   4'b0011);
        chk("t7_chg", chg0, 3'd2);
        tgt_data = 4'b1100;
        step();
        chk("t7_rdy", rdy0,  1'b0);
        chk("t7_by",  busy0, 1'b1);
        step();
        chk("t7_da",  done0, 1'b1);
        chk("t7_qa",  bank0, 4'b0011);
        step();
        tgt_valid = 1'b0;
        chk("t7_j0b", j0,    4'b1100);
        chk("t7_k0b", k0,    4'b0011);
        chk("t7_ch2", chg0,  3'd4);
        chk("t7_by2", busy0, 1'b1);
        chk("t7_dz",  done0, 1'b0);
        step(); step();
        chk("t7_db",  done0, 1'b1);
        chk("t7_qb",  bank0, 4'b1100);
        chk("t7_p0",  pass0, 8'd2);
        chk("t7_p1",  pass1, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
